// File: rtl/pixel_array_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_array_ctrl_if
//  Description : Valid/ready byte stream carrying pixel codes to readout logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pixel_array_ctrl_if #(
    parameter int COUNT_W = 8
);
    logic [COUNT_W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport master (output out_data, output out_valid, output out_last, input  out_ready);
    modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/pixel_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_array_ctrl
//  Description : 2x2 pixel array frame sequencer (erase/expose/convert/read)
//                with valid/ready pixel-code output. Define PIXEL_CTRL_CONT_EN
//                for continuous frames while start stays high.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_array_ctrl #(
    parameter int ERASE_CYC  = 5,
    parameter int EXPOSE_CYC = 255,
    parameter int READ_CYC   = 2,
    parameter int COUNT_W    = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   start,
    output logic                        busy,
    output logic                        px_erase,
    output logic                        px_expose,
    output logic                        px_convert,
    output logic                        px_read1,
    output logic                        px_read2,
    output logic [COUNT_W-1:0]          cnt_out,
    output logic                        cnt_oe,
    input  wire logic [4*COUNT_W-1:0]   data_in,
    pixel_array_ctrl_if.master          out_if
);

    localparam int c_W_A   = (COUNT_W > $clog2(ERASE_CYC))  ? COUNT_W : $clog2(ERASE_CYC);
    localparam int c_W_B   = (c_W_A   > $clog2(EXPOSE_CYC)) ? c_W_A   : $clog2(EXPOSE_CYC);
    localparam int c_TMR_W = (c_W_B   > $clog2(READ_CYC))   ? c_W_B   : $clog2(READ_CYC);

    localparam logic [c_TMR_W-1:0] c_ERASE_LAST  = c_TMR_W'(ERASE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_EXPOSE_LAST = c_TMR_W'(EXPOSE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_READ_LAST   = c_TMR_W'(READ_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_CONV_LAST   = c_TMR_W'({COUNT_W{1'b1}});

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_ERASE   = 4'd1;
    localparam logic [3:0] c_EXPOSE  = 4'd2;
    localparam logic [3:0] c_CONVERT = 4'd3;
    localparam logic [3:0] c_TURN    = 4'd4;
    localparam logic [3:0] c_READ1   = 4'd5;
    localparam logic [3:0] c_OUT1    = 4'd6;
    localparam logic [3:0] c_READ2   = 4'd7;
    localparam logic [3:0] c_OUT2    = 4'd8;

    logic [3:0]         r_state,   w_state_nxt;
    logic [c_TMR_W-1:0] r_tmr,     w_tmr_nxt;
    logic               r_beat,    w_beat_nxt;
    logic [COUNT_W-1:0] r_pix0,    w_pix0_nxt;
    logic [COUNT_W-1:0] r_pix1,    w_pix1_nxt;
    logic               w_accept;

    logic               r_busy, r_erase, r_expose, r_convert, r_read1, r_read2, r_cnt_oe;
    logic [COUNT_W-1:0] r_cnt_out, r_out_data;
    logic               r_out_valid, r_out_last;
    logic               w_busy, w_erase, w_expose, w_convert, w_read1, w_read2, w_cnt_oe;
    logic [COUNT_W-1:0] w_cnt_out, w_out_data;
    logic               w_out_valid, w_out_last;

    assign w_accept = r_out_valid & out_if.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_tmr   <= '0;
            r_beat  <= 1'b0;
            r_pix0  <= '0;
            r_pix1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_beat  <= w_beat_nxt;
            r_pix0  <= w_pix0_nxt;
            r_pix1  <= w_pix1_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + 1'b1;
        w_beat_nxt  = r_beat;
        w_pix0_nxt  = r_pix0;
        w_pix1_nxt  = r_pix1;
        case (r_state)
            c_IDLE: begin
                w_tmr_nxt  = '0;
                w_beat_nxt = 1'b0;
                if (start) w_state_nxt = c_ERASE;
            end
            c_ERASE: begin
                if (r_tmr == c_ERASE_LAST) begin
                    w_state_nxt = c_EXPOSE;
                    w_tmr_nxt   = '0;
                end
            end
            c_EXPOSE: begin
                if (r_tmr == c_EXPOSE_LAST) begin
                    w_state_nxt = c_CONVERT;
                    w_tmr_nxt   = '0;
                end
            end
            c_CONVERT: begin
                if (r_tmr == c_CONV_LAST) begin
                    w_state_nxt = c_TURN;
                    w_tmr_nxt   = '0;
                end
            end
            c_TURN: begin
                w_state_nxt = c_READ1;
                w_tmr_nxt   = '0;
            end
            c_READ1: begin
                // Row 1 codes are only trustworthy on the final read cycle.
                if (r_tmr == c_READ_LAST) begin
                    w_state_nxt = c_OUT1;
                    w_tmr_nxt   = '0;
                    w_beat_nxt  = 1'b0;
                    w_pix0_nxt  = data_in[0*COUNT_W +: COUNT_W];
                    w_pix1_nxt  = data_in[1*COUNT_W +: COUNT_W];
                end
            end
            c_OUT1: begin
                w_tmr_nxt = '0;
                if (w_accept) begin
                    if (!r_beat) begin
                        w_beat_nxt = 1'b1;
                    end else begin
                        w_beat_nxt  = 1'b0;
                        w_state_nxt = c_READ2;
                    end
                end
            end
            c_READ2: begin
                if (r_tmr == c_READ_LAST) begin
                    w_state_nxt = c_OUT2;
                    w_tmr_nxt   = '0;
                    w_beat_nxt  = 1'b0;
                    w_pix0_nxt  = data_in[2*COUNT_W +: COUNT_W];
                    w_pix1_nxt  = data_in[3*COUNT_W +: COUNT_W];
                end
            end
            c_OUT2: begin
                w_tmr_nxt = '0;
                if (w_accept) begin
                    if (!r_beat) begin
                        w_beat_nxt = 1'b1;
                    end else begin
                        w_beat_nxt = 1'b0;
`ifdef PIXEL_CTRL_CONT_EN
                        w_state_nxt = start ? c_ERASE : c_IDLE;
`else
                        w_state_nxt = c_IDLE;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_tmr_nxt   = '0;
                w_beat_nxt  = 1'b0;
            end
        endcase
    end

    // Outputs decode the next state so they can be registered without a cycle of lag.
    always_comb begin
        w_busy      = (w_state_nxt != c_IDLE);
        w_erase     = (w_state_nxt == c_ERASE);
        w_expose    = (w_state_nxt == c_EXPOSE);
        w_convert   = (w_state_nxt == c_CONVERT);
        w_read1     = (w_state_nxt == c_READ1);
        w_read2     = (w_state_nxt == c_READ2);
        w_cnt_oe    = w_convert;
        w_cnt_out   = w_convert ? w_tmr_nxt[COUNT_W-1:0] : '0;
        w_out_valid = (w_state_nxt == c_OUT1) || (w_state_nxt == c_OUT2);
        w_out_data  = '0;
        if (w_out_valid) w_out_data = w_beat_nxt ? w_pix1_nxt : w_pix0_nxt;
        w_out_last  = (w_state_nxt == c_OUT2) && w_beat_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy      <= 1'b0;
            r_erase     <= 1'b0;
            r_expose    <= 1'b0;
            r_convert   <= 1'b0;
            r_read1     <= 1'b0;
            r_read2     <= 1'b0;
            r_cnt_oe    <= 1'b0;
            r_cnt_out   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_busy      <= w_busy;
            r_erase     <= w_erase;
            r_expose    <= w_expose;
            r_convert   <= w_convert;
            r_read1     <= w_read1;
            r_read2     <= w_read2;
            r_cnt_oe    <= w_cnt_oe;
            r_cnt_out   <= w_cnt_out;
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
            r_out_last  <= w_out_last;
        end
    end

    assign busy             = r_busy;
    assign px_erase         = r_erase;
    assign px_expose        = r_expose;
    assign px_convert       = r_convert;
    assign px_read1         = r_read1;
    assign px_read2         = r_read2;
    assign cnt_oe           = r_cnt_oe;
    assign cnt_out          = r_cnt_out;
    assign out_if.out_data  = r_out_data;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_array_ctrl
//  Description : Scoreboard testbench for pixel_array_ctrl with a 2x2 array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_array_ctrl;

    localparam int c_CW        = 8;
    localparam int c_FRAME_CYC = 5 + 255 + 256 + 1 + 2 * 2 + 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, px_erase, px_expose, px_convert, px_read1, px_read2, cnt_oe;
    logic [c_CW-1:0]   cnt_out;
    logic [4*c_CW-1:0] data_in;
    logic [c_CW-1:0]   code11 = 8'h33, code12 = 8'h66, code21 = 8'h99, code22 = 8'hCC;

    int n_chk  = 0;
    int n_pass = 0;
    int beats  = 0;
    logic [c_CW:0] exp_q[$];

    pixel_array_ctrl_if #(.COUNT_W(c_CW)) out_if ();

    pixel_array_ctrl #(
        .ERASE_CYC (5),
        .EXPOSE_CYC(255),
        .READ_CYC  (2),
        .COUNT_W   (c_CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .px_erase  (px_erase),
        .px_expose (px_expose),
        .px_convert(px_convert),
        .px_read1  (px_read1),
        .px_read2  (px_read2),
        .cnt_out   (cnt_out),
        .cnt_oe    (cnt_oe),
        .data_in   (data_in),
        .out_if    (out_if.master)
    );

    always #5 clk = ~clk;

    // Array only drives a row while that row's read line is high.
    always_comb begin
        data_in = '0;
        if (px_read1) data_in[15:0]  = {code12, code11};
        if (px_read2) data_in[31:16] = {code22, code21};
    end

    // Per-cycle monitor: bus rules, counter ramp, stall stability, scoreboard.
    initial begin : monitor
        logic [c_CW-1:0] exp_cnt, prev_cnt, prev_data;
        logic            prev_oe, prev_valid, prev_ready, prev_last;
        logic [c_CW:0]   e;
        exp_cnt = '0; prev_cnt = '0; prev_data = '0;
        prev_oe = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_cnt = '0; prev_oe = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
            end else begin
                n_chk++;
                if ($countones({px_erase, px_expose, px_convert, px_read1, px_read2}) > 1)
                    $display("FAIL onehot: px={%b%b%b%b%b} required at most one high", px_erase, px_expose, px_convert, px_read1, px_read2);
                else n_pass++;
                n_chk++;
                if (cnt_oe && (px_read1 || px_read2))
                    $display("FAIL bus_contention: cnt_oe=%b read1=%b read2=%b required no overlap", cnt_oe, px_read1, px_read2);
                else n_pass++;
                n_chk++;
                if (cnt_oe) begin
                    if (cnt_out !== exp_cnt) $display("FAIL cnt_ramp: cnt_out=%h required %h", cnt_out, exp_cnt);
                    else n_pass++;
                    exp_cnt = exp_cnt + 1'b1;
                end else begin
                    if (cnt_out !== '0) $display("FAIL cnt_idle: cnt_out=%h required 00", cnt_out);
                    else n_pass++;
                    exp_cnt = '0;
                end
                if (prev_oe && !cnt_oe) begin
                    n_chk++;
                    if (prev_cnt !== 8'hFF) $display("FAIL cnt_end: last cnt_out=%h required ff", prev_cnt);
                    else n_pass++;
                end
                if (prev_valid && !prev_ready) begin
                    n_chk++;
                    if (out_if.out_valid !== 1'b1 || out_if.out_data !== prev_data || out_if.out_last !== prev_last)
                        $display("FAIL stall_hold: valid=%b data=%h last=%b required 1 %h %b", out_if.out_valid, out_if.out_data, out_if.out_last, prev_data, prev_last);
                    else n_pass++;
                end
                if (out_if.out_valid && out_if.out_ready) begin
                    n_chk++;
                    beats++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL extra_beat: data=%h last=%b required no beat", out_if.out_data, out_if.out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_if.out_last, out_if.out_data} !== e)
                            $display("FAIL beat: last/data=%b/%h required %b/%h", out_if.out_last, out_if.out_data, e[c_CW], e[c_CW-1:0]);
                        else n_pass++;
                    end
                end
                prev_oe = cnt_oe; prev_cnt = cnt_out;
                prev_valid = out_if.out_valid; prev_ready = out_if.out_ready;
                prev_data = out_if.out_data; prev_last = out_if.out_last;
            end
        end
    end

    task automatic push_frame(input logic [7:0] a, b, c, d);
        code11 = a; code12 = b; code21 = c; code22 = d;
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b0, c});
        exp_q.push_back({1'b1, d});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] a, b, c, d);
        int  busy_cyc;
        int  b0;
        bit  done;
        push_frame(a, b, c, d);
        b0 = beats;
        pulse_start();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || px_erase !== 1'b1) $display("FAIL frame_start: busy=%b px_erase=%b required 1 1", busy, px_erase);
        else n_pass++;
        busy_cyc = 0; done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            if (busy) busy_cyc++;
            else done = 1'b1;
            if (!done) @(negedge clk);
        end
        n_chk++;
        if (busy_cyc !== c_FRAME_CYC) $display("FAIL busy_len: busy cycles=%0d required %0d", busy_cyc, c_FRAME_CYC);
        else n_pass++;
        n_chk++;
        if (beats - b0 !== 4 || exp_q.size() !== 0) $display("FAIL frame_beats: beats=%0d pending=%0d required 4 0", beats - b0, exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({busy, px_erase, px_expose, px_convert, px_read1, px_read2, cnt_oe, out_if.out_valid, out_if.out_last, cnt_out, out_if.out_data} !== '0)
            $display("FAIL reset_outputs: busy=%b cnt_out=%h out_valid=%b required all 0", busy, cnt_out, out_if.out_valid);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, px_erase, cnt_oe, out_if.out_valid, cnt_out} !== '0)
            $display("FAIL idle_after_reset: busy=%b px_erase=%b cnt_out=%h required 0", busy, px_erase, cnt_out);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        run_frame(8'h33, 8'h66, 8'h99, 8'hCC);
    endtask

    task automatic test_patterns();
        run_frame(8'h00, 8'hFF, 8'h01, 8'h80);
        run_frame(8'hA5, 8'h5A, 8'hF0, 8'h0F);
    endtask

    task automatic test_backpressure();
        bit found;
        int b0;
        push_frame(8'h33, 8'h66, 8'h99, 8'hCC);
        b0 = beats;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (out_if.out_valid) found = 1'b1;
        end
        n_chk++;
        if (!found) $display("FAIL bp_timeout: out_valid=%b required 1", out_if.out_valid);
        else n_pass++;
        @(posedge clk); #1 out_if.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_if.out_data !== 8'h66 || out_if.out_valid !== 1'b1 || px_read2 !== 1'b0)
                $display("FAIL bp_hold: data=%h valid=%b px_read2=%b required 66 1 0", out_if.out_data, out_if.out_valid, px_read2);
            else n_pass++;
        end
        @(posedge clk); #1 out_if.out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        n_chk++;
        if (!found || beats - b0 !== 4 || exp_q.size() !== 0)
            $display("FAIL bp_done: busy=%b beats=%0d required 0 4", busy, beats - b0);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit found;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (cnt_oe && cnt_out == 8'h7F) found = 1'b1;
        end
        n_chk++;
        if (!found) $display("FAIL mid_timeout: cnt_out=%h required 7f", cnt_out);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (cnt_out !== 8'h80) $display("FAIL mid_cnt: cnt_out=%h required 80", cnt_out);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({busy, px_erase, px_expose, px_convert, px_read1, px_read2, cnt_oe, out_if.out_valid, out_if.out_last, cnt_out, out_if.out_data} !== '0)
            $display("FAIL mid_reset: busy=%b px_convert=%b cnt_out=%h required all 0", busy, px_convert, cnt_out);
        else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL mid_idle: busy=%b required 0", busy);
        else n_pass++;
        run_frame(8'h12, 8'h34, 8'h56, 8'h78);
    endtask

    task automatic test_start_ignored();
        bit found;
        bit rebusy;
        int b0;
        push_frame(8'h33, 8'h66, 8'h99, 8'hCC);
        b0 = beats;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (px_expose) found = 1'b1;
        end
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        n_chk++;
        if (!found || beats - b0 !== 4 || exp_q.size() !== 0)
            $display("FAIL ignore_frame: busy=%b beats=%0d required 0 4", busy, beats - b0);
        else n_pass++;
        rebusy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) rebusy = 1'b1;
        end
        n_chk++;
        if (rebusy !== 1'b0) $display("FAIL ignore_queued: busy seen=%b required 0", rebusy);
        else n_pass++;
        exp_q.delete();
    endtask

`ifdef PIXEL_CTRL_CONT_EN
    task automatic test_continuous();
        int  lasts;
        bit  hs_last, done;
        push_frame(8'h33, 8'h66, 8'h99, 8'hCC);
        push_frame(8'h33, 8'h66, 8'h99, 8'hCC);
        push_frame(8'h33, 8'h66, 8'h99, 8'hCC);
        @(posedge clk); #1 start = 1'b1;
        lasts = 0; hs_last = 1'b0; done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (hs_last) begin
                n_chk++;
                if (lasts < 3) begin
                    if (px_erase !== 1'b1) $display("FAIL cont_erase: px_erase=%b required 1", px_erase);
                    else n_pass++;
                end else begin
                    if (busy !== 1'b0) $display("FAIL cont_stop: busy=%b required 0", busy);
                    else n_pass++;
                    done = 1'b1;
                end
            end
            hs_last = out_if.out_valid && out_if.out_ready && out_if.out_last;
            if (hs_last) begin
                lasts++;
                if (lasts == 3) start = 1'b0;
            end
        end
        n_chk++;
        if (!done || lasts !== 3 || exp_q.size() !== 0) $display("FAIL cont_frames: lasts=%0d pending=%0d required 3 0", lasts, exp_q.size());
        else n_pass++;
        start = 1'b0;
        exp_q.delete();
    endtask
`endif

    initial begin
        out_if.out_ready = 1'b1;
        test_reset();
        test_single_frame();
        test_patterns();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
`ifdef PIXEL_CTRL_CONT_EN
        test_continuous();
`endif
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
